alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked, registered successor to the team's 8-bit combinational ALU.
- Operands are captured on a valid/ready transfer. Results and flags are registered and held until the consumer takes them.
- Adds an iterative shift-add multiplier, add-with-carry using the stored carry flag, and illegal-opcode reporting.
- Sits between the register file/input port and the datapath writeback stage.

Parameters:
- DATA, 8, operand/result width (≥2).
- SH, $clog2(DATA), shift-amount width.
- CMD, 4, function-select width (fixed opcode map below).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- FS  in  CMD  opcode.
- A  in  DATA  operand A.
- B  in  DATA  operand B.
- inpport  in  DATA  external input-port value.
- shift  in  SH  shift amount.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- out  out  DATA  registered result.
- N  out  1  negative flag.
- Z  out  1  zero flag.
- C  out  1  carry flag.
- V  out  1  overflow flag.
- err  out  1  illegal opcode, qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out=0, N=Z=C=V=0, err=0, out_valid=0, in_ready=1 after reset. Reset mid-multiply aborts it; no partial result is delivered.
- Accept when in_valid && in_ready. FS, A, B, inpport and shift are captured into internal registers; input changes after acceptance are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back acceptance in the DONE cycle is allowed.
- States:
  - IDLE: on accept of MUL → BUSY; on accept of any other op → DONE.
  - BUSY: one shift-add iteration per cycle, DATA iterations; counter reaches DATA → DONE.
  - DONE: out_valid=1; outputs held stable while out_ready=0. On out_ready: go to BUSY/DONE if a new request is accepted in the same cycle, else IDLE.
- Latency: single-cycle ops have out_valid high in the cycle after acceptance. MUL has out_valid high DATA+1 cycles after acceptance.
- Opcode map (results truncated to DATA bits):
  - 0 PASS: out=A, C=V=0.
  - 1 ADD: A+B; C=carry out; V=signed overflow.
  - 2 SUB: A-B; C=borrow (A<B unsigned); V=signed overflow.
  - 3 AND, 4 OR, 5 XOR, 6 NOT A: C=V=0.
  - 7 SHL: A<<shift; C=last bit shifted out (0 if shift=0); V=0.
  - 8 SHR logical: A>>shift; C=last bit shifted out (0 if shift=0); V=0.
  - 9 IN: out=inpport, C=V=0.
  - 10 MUL unsigned: out=low DATA bits of A*B; C=V=(high DATA bits != 0).
  - 11 ADC: A+B+C, where C is the stored flag from the previous completed op; C and V as for ADD.
  - 12-15 illegal: out=0, err=1, N/Z/C/V keep previous values.
- Flags: N=out[DATA-1], Z=(out==0) for every legal op. err=0 for every legal op.
- Flags and out update only on the transition into DONE. They persist after the handshake (out_valid low) until the next completion.

Test Plan:
- DATA=8, ADD, A=7A, B=52 → out=CC, N=1, Z=0, C=0, V=1, out_valid one cycle after accept.
- SUB, A=7A, B=52 → out=28, N=0, Z=0, C=0, V=0. SUB, A=52, B=7A → out=D8, C=1, V=0.
- MUL, A=7A, B=52 → out=14, C=V=1. out_valid rises exactly 9 cycles after accept; in_ready=0 throughout BUSY; A/B toggled during BUSY do not change the result.
- ADD FF+01 → out=00, Z=1, C=1; then ADC A=00, B=00 → out=01, C=0. SHL A=81, shift=1 → out=02, C=1. SHR A=81, shift=0 → out=81, C=0.
- out_ready held low 5 cycles in DONE → out/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (PASS A=3C) → new request accepted in the same cycle, out=3C in the next cycle.
- FS=0xE → err=1, out=00, flags unchanged. Assert rst_n=0 mid-MUL (cycle 4 of BUSY) → out_valid=0, out=0, flags=0, state IDLE, in_ready=1 after release.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked registered ALU with iterative shift-add multiplier and illegal-opcode reporting.
// Latency: 1 cycle for single-cycle ops, DATA+1 cycles for MUL; result held until out_ready.
// Backpressure: in_ready drops while multiplying or while a result waits for out_ready.
module alu_seq #(
    parameter int DATA = 8,
    parameter int SH   = $clog2(DATA),
    parameter int CMD  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CMD-1:0]  FS,
    input  logic [DATA-1:0] A,
    input  logic [DATA-1:0] B,
    input  logic [DATA-1:0] inpport,
    input  logic [SH-1:0]   shift,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out,
    output logic            N,
    output logic            Z,
    output logic            C,
    output logic            V,
    output logic            err
);

    localparam int MSB = DATA - 1;
    localparam int CW  = $clog2(DATA + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA);

    localparam logic [CMD-1:0] OP_PASS = CMD'(0);
    localparam logic [CMD-1:0] OP_ADD  = CMD'(1);
    localparam logic [CMD-1:0] OP_SUB  = CMD'(2);
    localparam logic [CMD-1:0] OP_AND  = CMD'(3);
    localparam logic [CMD-1:0] OP_OR   = CMD'(4);
    localparam logic [CMD-1:0] OP_XOR  = CMD'(5);
    localparam logic [CMD-1:0] OP_NOT  = CMD'(6);
    localparam logic [CMD-1:0] OP_SHL  = CMD'(7);
    localparam logic [CMD-1:0] OP_SHR  = CMD'(8);
    localparam logic [CMD-1:0] OP_IN   = CMD'(9);
    localparam logic [CMD-1:0] OP_MUL  = CMD'(10);
    localparam logic [CMD-1:0] OP_ADC  = CMD'(11);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic [DATA-1:0]   mcand;
    logic [2*DATA-1:0] prod;
    logic [2*DATA-1:0] prod_step;
    logic [DATA:0]     step_sum;

    logic              accept;
    logic              is_mul;
    logic              load_alu;
    logic              mul_done;

    logic [DATA:0]     sum;
    logic [DATA:0]     diff;
    logic [DATA:0]     shl;
    logic [DATA:0]     shr;
    logic [DATA-1:0]   alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              alu_err;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (FS == OP_MUL);
    assign load_alu  = accept && !is_mul;

    // The DATA-th iteration's sum feeds the result register directly, so the
    // last BUSY cycle both finishes the product and enters DONE.
    assign step_sum  = {1'b0, prod[2*DATA-1:DATA]} + {1'b0, (prod[0] ? mcand : {DATA{1'b0}})};
    assign prod_step = {step_sum, prod[DATA-1:1]};
    assign cnt_inc   = cnt + 1'b1;
    assign mul_done  = (state == BUSY) && (cnt_inc == CNT_LAST);

    always_comb begin
        sum     = {1'b0, A} + {1'b0, B} + {{DATA{1'b0}}, ((FS == OP_ADC) ? C : 1'b0)};
        diff    = {1'b0, A} - {1'b0, B};
        shl     = {1'b0, A} << shift;
        shr     = {A, 1'b0} >> shift;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (FS)
            OP_PASS: alu_res = A;
            OP_ADD, OP_ADC: begin
                alu_res = sum[DATA-1:0];
                alu_c   = sum[DATA];
                alu_v   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[DATA-1:0];
                alu_c   = diff[DATA];
                alu_v   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOT: alu_res = ~A;
            OP_SHL: begin
                alu_res = shl[DATA-1:0];
                alu_c   = shl[DATA];
            end
            OP_SHR: begin
                alu_res = shr[DATA:1];
                alu_c   = shr[0];
            end
            OP_IN:  alu_res = inpport;
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_mul ? BUSY : DONE;
            BUSY: if (mul_done) state_nxt = DONE;
            DONE: begin
                if (accept)         state_nxt = is_mul ? BUSY : DONE;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            out   <= '0;
            N     <= 1'b0;
            Z     <= 1'b0;
            C     <= 1'b0;
            V     <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept && is_mul) begin
                mcand <= A;
                prod  <= {{DATA{1'b0}}, B};
                cnt   <= '0;
            end else if (state == BUSY) begin
                prod <= prod_step;
                cnt  <= cnt_inc;
            end

            // Illegal opcodes clear the result but leave N/Z/C/V from the last legal op.
            if (load_alu) begin
                out <= alu_res;
                err <= alu_err;
                if (!alu_err) begin
                    N <= alu_res[MSB];
                    Z <= (alu_res == '0);
                    C <= alu_c;
                    V <= alu_v;
                end
            end else if (mul_done) begin
                out <= prod_step[DATA-1:0];
                err <= 1'b0;
                N   <= prod_step[MSB];
                Z   <= (prod_step[DATA-1:0] == '0);
                C   <= |prod_step[2*DATA-1:DATA];
                V   <= |prod_step[2*DATA-1:DATA];
            end
        end
    end

endmodule
